arcino_multdiv_seq: RTL and testbench
=====================================

# arcino_multdiv_seq

Iterative multiply/divide sequencer for the ARCINO RISC-V core, serving the M-extension operations encoded by `md_op_e` (MULL, MULH, DIV, REM). It sits beside the ALU in the EX stage. It accepts one operation at a time from the ID/EX controller and runs a 32-step shift-add multiply or restoring divide on a shared accumulator, adding sign pre/post-correction and the RISC-V divide corner cases. It returns a single-cycle `valid_o` pulse with the 32-bit result, and has a fixed latency so the ID stage can stall deterministically.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk_i`  in  1  core clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `mult_en_i`  in  1  multiply request; held high until `valid_o`
- `div_en_i`  in  1  divide request; held high until `valid_o`
- `operator_i`  in  2  `md_op_e`: MULL, MULH, DIV, REM
- `signed_mode_i`  in  2  bit0 = `op_a_i` is signed, bit1 = `op_b_i` is signed
- `op_a_i`  in  32  multiplicand / dividend
- `op_b_i`  in  32  multiplier / divisor
- `result_o`  out  32  result; registered; holds its value until the next accept
- `valid_o`  out  1  result valid; one-cycle pulse
- `busy_o`  out  1  high in CALC and FINISH

## Operation
- `en = mult_en_i | div_en_i`. The operation is selected by `operator_i` alone.
- `operator_i` and `op_*_i` are sampled only at accept. They may change afterwards.
- FSM states: IDLE, CALC, FINISH.
  - IDLE -> CALC when `en`. This is the accept cycle.
  - CALC -> FINISH when `cnt == 0`. CALC -> IDLE when `en` falls (abort).
  - FINISH -> IDLE unconditionally.
- Accept latches:
  - `neg_a = signed_mode_i[0] & op_a_i[31]` and `neg_b = signed_mode_i[1] & op_b_i[31]`.
  - `|a|` and `|b|` as 32-bit unsigned. |0x80000000| = 0x80000000.
  - `div_zero = (op_b_i == 0)`, raw `op_a_i`, and the operator.
  - `cnt = 31`.
- MUL step, per CALC cycle:
  - 65-bit accumulator `{hi[32:0], lo[31:0]}`, where `lo` starts as `|b|` and `hi` starts at 0.
  - If `lo[0]`, `hi += |a|`. Then shift the whole accumulator right by 1.
  - After 32 steps, `prod[63:0] = acc[63:0]`.
- DIV step, per CALC cycle (restoring division):
  - `rem[32:0]` starts at 0. `q` starts as `|a|`.
  - `rem = {rem[31:0], q[31]}`, `q <<= 1`.
  - If `rem >= {1'b0,|b|}`, then `rem -= |b|` and `q[0] = 1`.
- FINISH computes and registers `result_o`:
  - MULL: `prod'[31:0]`. MULH: `prod'[63:32]`. Here `prod' = (neg_a ^ neg_b) ? -prod : prod`, computed at 64 bits.
  - DIV: `(neg_a ^ neg_b) ? -q : q`.
  - REM: `neg_a ? -rem[31:0] : rem[31:0]`.
  - When `div_zero`, this override applies: DIV = 0xFFFFFFFF, REM = raw `op_a`, with no sign correction.
  - Overflow (0x80000000 / -1, signed) needs no special case: DIV = 0x80000000, REM = 0.
- `mult_en_i` and `div_en_i` both high is illegal. The block still executes `operator_i`.
- A rising `en` in FINISH is ignored. A new accept occurs only from IDLE.

## Timing
- Reset values: state IDLE, `result_o = 0`, `valid_o = 0`, `busy_o = 0`, `cnt = 0`, and the accumulator cleared.
- Latency is fixed for every operator and operand, including divide-by-zero. With accept in cycle 0:
  - CALC occupies cycles 1–32.
  - FINISH is cycle 33. `valid_o` is high in cycle 33 only.
  - `result_o` becomes valid in cycle 34 (registered at the end of FINISH).
  - Correction: `result_o` must be valid together with `valid_o`. FINISH's result is therefore registered on the CALC->FINISH edge, using the final step's next-state value plus sign correction, so `result_o` is valid in cycle 33.
- Throughput: one operation per 34 cycles. The requester drops `en` in cycle 34 or starts a new operation (accept in cycle 34).
- Abort: `en` low in any CALC cycle makes the next state IDLE. There is no `valid_o`, and `result_o` keeps its previous value.
- `en` low in FINISH still produces `valid_o`.
- Reset mid-operation returns the block immediately to reset values.

## Test plan
- Signed MULH 0x80000000 × 0x80000000 (mode 11) -> `valid_o` exactly 33 cycles after accept, `result_o` = 0x40000000. The same operands with MULL -> 0x00000000.
- MULL 7 × 0xFFFFFFFD (mode 11) -> 0xFFFFFFEB. MULH with mode 01 (MULHSU), 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULH with mode 00 on the same operands -> 0xFFFFFFFE.
- Signed DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. Unsigned DIV of the same operands -> 0x7FFFFFFC.
- DIV 5 / 0 -> 0xFFFFFFFF. REM 0xFFFFFFF9 / 0 (signed) -> 0xFFFFFFF9. Signed DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- Drop `div_en_i` in cycle 10 -> no `valid_o`, `result_o` unchanged, next accept proceeds normally. Drive back-to-back operations with `en` held through cycle 34 -> second `valid_o` in cycle 67.
- Assert `rst_ni` low in cycle 20 of a multiply -> all outputs 0 immediately. After release, a fresh MULL 3 × 4 -> 12.

Source files
------------

// File: rtl/arcino_multdiv_seq.sv
// Iterative 32-bit multiply/divide sequencer for the M extension.
// Shift-add multiply and restoring divide share one 65-bit accumulator.
module arcino_multdiv_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        valid_o,
  output logic        busy_o
);

  // state  | meaning
  // IDLE   | waiting for a request; operands latched on accept
  // CALC   | one multiply/divide step per cycle, 32 steps
  // FINISH | valid_o pulse; result_o already holds the answer

  typedef enum logic [1:0] {MD_MULL, MD_MULH, MD_DIV, MD_REM} md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_e;

  state_e      state_q, state_d;
  md_op_e      op_q;
  logic        en;
  logic [4:0]  cnt_q;
  logic [64:0] acc_q, step_acc;
  logic [31:0] abs_a_q, abs_b_q, raw_a_q;
  logic        neg_a_q, neg_b_q, div_zero_q;

  logic        neg_a_in, neg_b_in;
  logic [31:0] abs_a_in, abs_b_in;
  logic [32:0] hi_sum, rem_sh;
  logic [31:0] q_sh;
  logic [63:0] prod, prod_s;
  logic [31:0] quot, rem, result_d;
  logic        sgn;

  assign en = mult_en_i | div_en_i;

  assign neg_a_in = signed_mode_i[0] & op_a_i[31];
  assign neg_b_in = signed_mode_i[1] & op_b_i[31];
  assign abs_a_in = neg_a_in ? -op_a_i : op_a_i;
  assign abs_b_in = neg_b_in ? -op_b_i : op_b_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    valid_o = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_CALC;
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (!en)              state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        busy_o  = 1'b1;
        valid_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One iteration: multiply uses {hi,lo}, divide uses {rem,q} in the same register.
  always_comb begin
    hi_sum = acc_q[64:32] + (acc_q[0] ? {1'b0, abs_a_q} : 33'd0);
    rem_sh = {acc_q[63:32], acc_q[31]};
    q_sh   = {acc_q[30:0], 1'b0};
    if (op_q == MD_MULL || op_q == MD_MULH) begin
      step_acc = {1'b0, hi_sum, acc_q[31:1]};
    end else if (rem_sh >= {1'b0, abs_b_q}) begin
      step_acc = {rem_sh - {1'b0, abs_b_q}, q_sh | 32'd1};
    end else begin
      step_acc = {rem_sh, q_sh};
    end
  end

  // Result is formed from the final step's next value so it lands with valid_o.
  always_comb begin
    sgn    = neg_a_q ^ neg_b_q;
    prod   = step_acc[63:0];
    prod_s = sgn ? -prod : prod;
    quot   = step_acc[31:0];
    rem    = step_acc[63:32];
    case (op_q)
      MD_MULL: result_d = prod_s[31:0];
      MD_MULH: result_d = prod_s[63:32];
      MD_DIV:  result_d = div_zero_q ? 32'hFFFF_FFFF : (sgn ? -quot : quot);
      MD_REM:  result_d = div_zero_q ? raw_a_q : (neg_a_q ? -rem : rem);
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= MD_MULL;
      cnt_q      <= '0;
      acc_q      <= '0;
      abs_a_q    <= '0;
      abs_b_q    <= '0;
      raw_a_q    <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      result_o   <= '0;
    end else begin
      if (state_q == S_IDLE && en) begin
        op_q       <= md_op_e'(operator_i);
        cnt_q      <= 5'd31;
        abs_a_q    <= abs_a_in;
        abs_b_q    <= abs_b_in;
        raw_a_q    <= op_a_i;
        neg_a_q    <= neg_a_in;
        neg_b_q    <= neg_b_in;
        div_zero_q <= (op_b_i == '0);
        acc_q      <= {33'd0, operator_i[1] ? abs_a_in : abs_b_in};
      end else if (state_q == S_CALC && en) begin
        acc_q <= step_acc;
        cnt_q <= cnt_q - 5'd1;
        if (cnt_q == '0) result_o <= result_d;
      end
    end
  end

endmodule

// File: tb/tb_arcino_multdiv_seq.sv
// Directed-vector bench for arcino_multdiv_seq: results, latency, abort,
// back-to-back issue and mid-operation reset.
module tb_arcino_multdiv_seq;

  localparam logic [1:0] OP_MULL = 2'd0;
  localparam logic [1:0] OP_MULH = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_REM  = 2'd3;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        mult_en_i, div_en_i;
  logic [1:0]  operator_i, signed_mode_i;
  logic [31:0] op_a_i, op_b_i, result_o;
  logic        valid_o, busy_o;

  int n_vec  = 0;
  int n_miss = 0;

  arcino_multdiv_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mult_en_i(mult_en_i), .div_en_i(div_en_i),
    .operator_i(operator_i), .signed_mode_i(signed_mode_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .result_o(result_o), .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b);
    operator_i    = op;
    signed_mode_i = mode;
    op_a_i        = a;
    op_b_i        = b;
    mult_en_i     = ~op[1];
    div_en_i      = op[1];
  endtask

  // Returns the cycle index (after accept) where valid_o is seen; 40 on timeout.
  task automatic wait_valid(output int k);
    k = 0;
    do begin
      @(posedge clk_i);
      @(negedge clk_i);
      k++;
    end while (!valid_o && k < 40);
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [1:0] mode,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int k;
    drive(op, mode, a, b);
    wait_valid(k);
    chk({tag, "_lat"}, 32'(k), 32'd33);
    chk(tag, result_o, exp);
    mult_en_i = 1'b0;
    div_en_i  = 1'b0;
    op_a_i    = 32'h0BAD_F00D;
    @(posedge clk_i);
    @(negedge clk_i);
    chk({tag, "_pulse"}, {31'd0, valid_o}, 32'd0);
    chk({tag, "_hold"}, result_o, exp);
  endtask

  initial begin
    int k, k2, pulses;
    rst_ni = 1'b0;
    mult_en_i = 1'b0; div_en_i = 1'b0;
    operator_i = 2'd0; signed_mode_i = 2'd0; op_a_i = '0; op_b_i = '0;
    @(negedge clk_i);
    chk("rst_result", result_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    run("mulh_min_sq", OP_MULH, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mull_min_sq", OP_MULL, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
    run("mull_7xm3",   OP_MULL, 2'b11, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulhsu",      OP_MULH, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhu",       OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("div_m7_2",    OP_DIV,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run("rem_m7_2",    OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run("divu_7",      OP_DIV,  2'b00, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC);
    run("div_by0",     OP_DIV,  2'b11, 32'd5,         32'd0,         32'hFFFF_FFFF);
    run("rem_by0",     OP_REM,  2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    run("div_ovf",     OP_DIV,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",     OP_REM,  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // Abort: div_en_i low in cycle 10 after accept.
    drive(OP_DIV, 2'b00, 32'd1000, 32'd7);
    repeat (10) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    div_en_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      if (valid_o) pulses++;
    end
    chk("abort_valid", 32'(pulses), 32'd0);
    chk("abort_result", result_o, 32'h0000_0000);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    run("after_abort", OP_DIV, 2'b00, 32'd1000, 32'd7, 32'd142);

    // Back-to-back: en held through cycle 34, second op accepted there.
    drive(OP_MULL, 2'b00, 32'd6, 32'd9);
    wait_valid(k);
    chk("b2b_first_lat", 32'(k), 32'd33);
    chk("b2b_first", result_o, 32'd54);
    drive(OP_REM, 2'b00, 32'd100, 32'd7);
    wait_valid(k2);
    chk("b2b_second_lat", 32'(k + k2), 32'd67);
    chk("b2b_second", result_o, 32'd2);
    mult_en_i = 1'b0;
    div_en_i  = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);

    // Reset in cycle 20 of a multiply.
    drive(OP_MULL, 2'b00, 32'd11, 32'd13);
    repeat (20) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    rst_ni = 1'b0;
    #1;
    chk("midrst_result", result_o, 32'd0);
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    mult_en_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run("post_rst_3x4", OP_MULL, 2'b11, 32'd3, 32'd4, 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
